// File: rtl/a0_trace.sv
// rtl/a0_trace.sv - a0 change tracer with timestamped FWFT queue
//
// Watches the core's a0 result register every cycle and queues each new value,
// tagged with a free-running cycle timestamp, into a first-word-fall-through
// FIFO that a consumer drains through a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   a0_in      a0 value from the core
//   en         capture enable; sampling is suspended while low
//   out_valid  head entry available
//   out_ready  consumer accepts the head entry
//   out_data   a0 value of the head entry (0 when empty)
//   out_ts     timestamp of the head entry (0 when empty)
//   count      entries currently held
//   overflow   sticky flag: a change was dropped because the FIFO was full
//   clr_ovf    synchronous clear of overflow

module a0_trace #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              a0_in,
    input  logic                     en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TS_WIDTH-1:0] ts;
    logic [31:0]         prev;
    logic                primed;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    logic [31:0]         mem_data [DEPTH];
    logic [TS_WIDTH-1:0] mem_ts   [DEPTH];

    logic change;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // The first enabled sample after reset always counts as a change, so the
    // reset value of prev never masks a genuine a0 value of 0.
    assign change = en && (!primed || (a0_in != prev));
    assign full   = (count == CW'(DEPTH));
    assign pop    = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push   = change && (!full || pop);
    assign drop   = change && full && !pop;

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_ts    = out_valid ? mem_ts[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts       <= '0;
            prev     <= '0;
            primed   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + TS_WIDTH'(1);

            if (en) begin
                prev   <= a0_in;
                primed <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A drop on the same edge as a clear keeps the flag set so the
            // loss is never silently hidden.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= a0_in;
            mem_ts[wr_ptr]   <= ts;
        end
    end

endmodule

// File: tb/tb_a0_trace.sv
// tb/tb_a0_trace.sv - scoreboard bench for a0_trace
module tb_a0_trace;

    localparam int DEPTH = 8;
    localparam int TSW   = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [31:0]           a0_in = '0;
    logic                  en = 1'b0;
    logic                  out_ready = 1'b0;
    logic                  clr_ovf = 1'b0;
    logic                  out_valid;
    logic [31:0]           out_data;
    logic [TSW-1:0]        out_ts;
    logic [$clog2(DEPTH):0] count;
    logic                  overflow;

    a0_trace #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a0_in     (a0_in),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [31:0]    d;
        logic [TSW-1:0] t;
    } ent_t;

    ent_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sb_push(input logic [31:0] d, input logic [TSW-1:0] t);
        sb.push_back('{d: d, t: t});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        a0_in = '0;
        out_ready = 1'b0;
        clr_ovf = 1'b0;
        sb.delete();
        step(2);
        rst = 1'b1;
    endtask

    // Monitor: sample away from the active edge; a handshake seen here is the
    // pop that the next rising edge performs.
    ent_t e;
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL pop_unexpected: got data 0x%0h ts 0x%0h, expected no entry", out_data, out_ts);
            end else begin
                e = sb.pop_front();
                check("pop_data", out_data, e.d);
                check("pop_ts", 32'(out_ts), 32'(e.t));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[6];
        vals = '{5, 5, 7, 7, 7, 9};

        // Reset state
        do_reset();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_data", out_data, 0);
        check("rst_ts", 32'(out_ts), 0);
        rst = 1'b1;

        // a0 held at 0: only the priming sample is captured
        en = 1'b1;
        a0_in = 0;
        sb_push(0, 0);
        step(5);
        check("t1_count", 32'(count), 1);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_ovf", 32'(overflow), 0);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("t1_empty", 32'(count), 0);

        // Change detection on 5,5,7,7,7,9
        do_reset();
        en = 1'b1;
        sb_push(5, 0);
        sb_push(7, 2);
        sb_push(9, 5);
        for (int i = 0; i < 6; i++) begin
            a0_in = vals[i];
            step(1);
        end
        check("t2_count", 32'(count), 3);
        check("t2_head", out_data, 5);
        step(2);
        check("t2_stable_data", out_data, 5);
        check("t2_stable_ts", 32'(out_ts), 0);
        out_ready = 1'b1;
        step(3);
        out_ready = 1'b0;
        check("t2_valid_low", 32'(out_valid), 0);
        check("t2_count0", 32'(count), 0);

        // Overflow: 1..10, only 1..8 retained
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            a0_in = i;
            if (i <= 8) sb_push(i, TSW'(i - 1));
            step(1);
        end
        check("t3_count", 32'(count), 8);
        check("t3_ovf", 32'(overflow), 1);
        check("t3_head", out_data, 1);
        // drop and clear on the same edge: set wins
        clr_ovf = 1'b1;
        a0_in = 12;
        step(1);
        check("t3_ovf_setwins", 32'(overflow), 1);
        check("t3_count_hold", 32'(count), 8);
        step(1);
        clr_ovf = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 0);

        // Full with simultaneous pop and push
        out_ready = 1'b1;
        a0_in = 11;
        sb_push(11, 12);
        step(1);
        out_ready = 1'b0;
        check("t4_count", 32'(count), 8);
        check("t4_ovf", 32'(overflow), 0);
        out_ready = 1'b1;
        step(8);
        out_ready = 1'b0;
        check("t4_drained", 32'(count), 0);

        // Timestamp wrap with en low for 17 cycles
        do_reset();
        en = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            a0_in = 100 + i;
            step(1);
        end
        check("t5_no_capture", 32'(count), 0);
        en = 1'b1;
        a0_in = 3;
        sb_push(3, 1);
        step(1);
        check("t5_count", 32'(count), 1);
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(1);
        check("t5_no_retrigger", 32'(count), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;

        // Asynchronous reset with entries pending
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            a0_in = i;
            step(1);
        end
        check("t6_count", 32'(count), 5);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 0);
        check("t6_async_count", 32'(count), 0);
        check("t6_async_ovf", 32'(overflow), 0);
        check("t6_async_data", out_data, 0);
        check("t6_async_ts", 32'(out_ts), 0);
        sb.delete();
        step(1);
        rst = 1'b1;
        en = 1'b1;
        a0_in = 0;
        sb_push(0, 0);
        step(1);
        check("t6_primed_capture", 32'(count), 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(1);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/a0_trace.md
Name: a0_trace

Overview:
- Downstream observer for the cpu core's a0 result register.
- Samples a0 every cycle and detects value changes.
- Each change is queued, with a cycle timestamp, into a small first-word-fall-through FIFO.
- A testbench, UART bridge or display driver drains the FIFO through a valid/ready handshake, so a0 history is captured without stalling the core.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_WIDTH, 16, timestamp counter width in bits.

Ports:
- clk  in  1  system clock; rising-edge.
- rst  in  1  asynchronous, active-low reset.
- a0_in  in  32  a0 output of cpu.
- en  in  1  capture enable; when low, no sampling occurs.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  32  a0 value of the head entry.
- out_ts  out  TS_WIDTH  timestamp of the head entry.
- count  out  $clog2(DEPTH)+1  entries currently held.
- overflow  out  1  sticky: a change was dropped because the FIFO was full.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst low, asynchronous, immediate):
  - ts, prev, primed, read/write pointers, count and overflow all clear to 0.
  - out_valid=0, out_data=0, out_ts=0.
  - FIFO contents are discarded; storage itself needs no reset.
  - Reset mid-operation drops all pending entries with no partial pop.
- Timestamp:
  - ts increments by 1 on every clk edge out of reset, independent of en.
  - Wraps from 2^TS_WIDTH-1 to 0.
  - The first edge after reset release is cycle 0.
- Change detection, evaluated at each edge:
  - change = en && (!primed || a0_in != prev).
  - When en=1: prev <= a0_in and primed <= 1.
  - When en=0: prev and primed hold.
  - A pushed entry is {a0_in, ts}, where ts is the pre-increment value for that edge.
- FIFO:
  - push = change && (count<DEPTH || pop).
  - pop = out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged; this is legal even when full.
  - When full with no pop: the change is dropped and overflow is set.
  - Pointers wrap modulo DEPTH.
- Outputs:
  - out_valid = (count!=0).
  - out_data and out_ts are driven combinationally from the head entry, and forced to 0 when count==0.
  - out_data and out_ts must stay stable while out_valid=1 && out_ready=0.
  - Latency: a change sampled at edge N gives out_valid=1 after edge N; out_data is visible in the cycle following edge N.
  - count updates on the edge where the push or pop occurs.
- Overflow:
  - Set by a dropped push; cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, set wins (overflow stays 1).
- out_ready while empty has no effect.
- en only gates sampling; draining continues while en=0.

Test Plan:
- Reset release, en=1, a0_in=0 held for 5 cycles, out_ready=0 → count=1; head is {0, ts=0}; overflow=0.
- en=1, out_ready=0, a0_in over cycles 0..5 = 5,5,7,7,7,9 → count=3.
  - Then assert out_ready → entries {5,0}, {7,2}, {9,5} in order.
  - out_valid falls after the third pop.
- DEPTH=8, out_ready=0, a0_in = 1..10, a new value every cycle → count=8, retained entries 1..8, overflow=1.
  - Pulse clr_ovf → overflow=0.
  - Drain → entries 1..8, ts 0..7.
- FIFO full (count=8) with out_ready=1 and a new a0_in value on the same cycle → count stays 8, overflow stays 0, and the new value becomes the tail entry.
- TS_WIDTH=4, en=0 for cycles 0..16, then en=1 with a0_in=3 at cycle 17 → captured entry {3, ts=1}, confirming the wrap from 15 to 0.
  - Toggling en low then back high with a0_in unchanged → no new entry.
- count=5, rst driven low between clock edges → out_valid, count, overflow, out_data and out_ts are 0 immediately, without waiting for a clock edge.
  - After release, the first en=1 sample is captured, since primed was cleared.
